// File: rtl/cache_tag_store_pkg.sv
// cache_tag_pkg: shared widths, entry type and flush states
// for the way-halting set-associative tag store.
package cache_tag_pkg;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   localparam int TAG_W_DEF  = 20;
   localparam int HALT_W_DEF = 4;
   localparam int SETS_DEF   = 16;
   localparam int WAYS_DEF   = 4;

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_DEF-1:0] tag;
   } tag_entry_t;

   typedef enum logic [1:0] {
      FL_IDLE,
      FL_RUN,
      FL_DONE
   } fl_state_t;

endpackage

// File: rtl/cache_tag_store_if.sv
// cache_tag_store_if: lookup, fill, invalidate and flush signals
// between the cache controller (master) and the tag store (slave).
interface cache_tag_store_if #(
   parameter int TAG_W = 20,
   parameter int IDX_W = 4,
   parameter int WAY_W = 2,
   parameter int WAYS  = 4
);
   logic             ready;
   logic             lkp_valid;
   logic [IDX_W-1:0] lkp_index;
   logic [TAG_W-1:0] lkp_tag;
   logic             rsp_valid;
   logic             rsp_hit;
   logic [WAY_W-1:0] rsp_way;
   logic [WAYS-1:0]  rsp_halt_mask;
   logic             fill_valid;
   logic [IDX_W-1:0] fill_index;
   logic [TAG_W-1:0] fill_tag;
   logic             fill_done;
   logic [WAY_W-1:0] fill_way;
   logic             evict_valid;
   logic [TAG_W-1:0] evict_tag;
   logic             inv_valid;
   logic [IDX_W-1:0] inv_index;
   logic [WAY_W-1:0] inv_way;
   logic             inv_ready;
   logic             flush_req;
   logic             flush_done;

   modport master (
      input  ready, rsp_valid, rsp_hit, rsp_way, rsp_halt_mask,
      input  fill_done, fill_way, evict_valid, evict_tag,
      input  inv_ready, flush_done,
      output lkp_valid, lkp_index, lkp_tag,
      output fill_valid, fill_index, fill_tag,
      output inv_valid, inv_index, inv_way, flush_req
   );

   modport slave (
      output ready, rsp_valid, rsp_hit, rsp_way, rsp_halt_mask,
      output fill_done, fill_way, evict_valid, evict_tag,
      output inv_ready, flush_done,
      input  lkp_valid, lkp_index, lkp_tag,
      input  fill_valid, fill_index, fill_tag,
      input  inv_valid, inv_index, inv_way, flush_req
   );
endinterface

// File: rtl/cache_tag_store_lru.sv
// cache_tag_lru: true-LRU age update for one set and the
// oldest-way victim; purely combinational.
module cache_tag_lru #(
   parameter int WAYS  = 4,
   parameter int WAY_W = 2
) (
   input  logic [WAYS-1:0][WAY_W-1:0] age,
   input  logic [WAY_W-1:0]           touch,
   output logic [WAYS-1:0][WAY_W-1:0] age_nxt,
   output logic [WAY_W-1:0]           victim
);
   always_comb begin
      age_nxt = age;
      victim  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (w == int'(touch)) begin
            age_nxt[w] = '0;
         end else if (age[w] < age[touch]) begin
            age_nxt[w] = age[w] + 1'b1;
         end
         if (age[w] == WAY_W'(WAYS-1)) begin
            victim = WAY_W'(w);
         end
      end
   end
endmodule

// File: rtl/cache_tag_store.sv
// cache_tag_store: set-associative tag store with halt-tag filtering,
// LRU fill/evict, single-way invalidate and a set-by-set flush.
module cache_tag_store
   import cache_tag_pkg::*;
#(
   parameter int TAG_W  = TAG_W_DEF,
   parameter int HALT_W = HALT_W_DEF,
   parameter int SETS   = SETS_DEF,
   parameter int WAYS   = WAYS_DEF
) (
   input logic              clk,
   input logic              reset,
   cache_tag_store_if.slave bus
);
   localparam int IDX_W = clog2(SETS);
   localparam int WAY_W = clog2(WAYS);

   logic [WAYS-1:0]            vld  [SETS];
   logic [WAYS-1:0][TAG_W-1:0] tags [SETS];
   logic [WAYS-1:0][WAY_W-1:0] age  [SETS];

   fl_state_t        state, state_nxt;
   logic [IDX_W-1:0] fl_cnt;
   logic             rdy, fl_clr;
   logic             acc_lkp, acc_fill, acc_inv;

   logic [WAYS-1:0]  halt_mask;
   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic [WAY_W-1:0] fill_sel;
   logic             fill_evict;

   logic [IDX_W-1:0]           upd_idx;
   logic                       upd_en;
   logic [WAYS-1:0][WAY_W-1:0] lru_age, lru_nxt;
   logic [WAY_W-1:0]           lru_touch, lru_vic;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FL_IDLE;
         fl_cnt <= '0;
      end else begin
         state  <= state_nxt;
         fl_cnt <= (state == FL_RUN) ? fl_cnt + 1'b1 : '0;
      end
   end

   always_comb begin
      state_nxt      = state;
      rdy            = 1'b1;
      fl_clr         = 1'b0;
      bus.flush_done = 1'b0;
      unique case (state)
         FL_IDLE, FL_DONE: begin
            bus.flush_done = (state == FL_DONE);
            state_nxt = bus.flush_req ? FL_RUN : FL_IDLE;
         end
         FL_RUN: begin
            rdy    = 1'b0;
            fl_clr = 1'b1;
            if (fl_cnt == IDX_W'(SETS-1)) state_nxt = FL_DONE;
         end
         default: state_nxt = FL_IDLE;
      endcase
   end

   assign bus.ready     = rdy;
   assign bus.inv_ready = rdy & ~bus.fill_valid;
   assign acc_lkp  = rdy & bus.lkp_valid;
   assign acc_fill = rdy & bus.fill_valid;
   assign acc_inv  = rdy & ~bus.fill_valid & bus.inv_valid;

   // full compare only where the halt tag already matched
   always_comb begin
      logic m;
      halt_mask = '0;
      hit       = 1'b0;
      hit_way   = '0;
      for (int w = WAYS-1; w >= 0; w--) begin
         m = vld[bus.lkp_index][w] &
             (tags[bus.lkp_index][w][HALT_W-1:0] ==
              bus.lkp_tag[HALT_W-1:0]);
         halt_mask[w] = m;
         if (m && (tags[bus.lkp_index][w] == bus.lkp_tag)) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // one LRU unit: a fill owns it, otherwise a lookup hit
   assign upd_idx   = acc_fill ? bus.fill_index : bus.lkp_index;
   assign upd_en    = acc_fill | (acc_lkp & hit);
   assign lru_age   = age[upd_idx];
   assign lru_touch = acc_fill ? fill_sel : hit_way;

   cache_tag_lru #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_lru (
      .age     (lru_age),
      .touch   (lru_touch),
      .age_nxt (lru_nxt),
      .victim  (lru_vic)
   );

   always_comb begin
      logic found;
      fill_sel = lru_vic;
      found    = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !vld[bus.fill_index][w]) begin
            fill_sel = WAY_W'(w);
            found    = 1'b1;
         end
      end
      fill_evict = ~found;
   end

   always_ff @(posedge clk) begin
      if (acc_fill) tags[bus.fill_index][fill_sel] <= bus.fill_tag;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            vld[s] <= '0;
            for (int w = 0; w < WAYS; w++) age[s][w] <= WAY_W'(w);
         end
         bus.rsp_valid     <= 1'b0;
         bus.rsp_hit       <= 1'b0;
         bus.rsp_way       <= '0;
         bus.rsp_halt_mask <= '0;
         bus.fill_done     <= 1'b0;
         bus.fill_way      <= '0;
         bus.evict_valid   <= 1'b0;
         bus.evict_tag     <= '0;
      end else begin
         bus.rsp_valid   <= acc_lkp;
         bus.fill_done   <= acc_fill;
         bus.evict_valid <= acc_fill & fill_evict;
         if (acc_lkp) begin
            bus.rsp_hit       <= hit;
            bus.rsp_way       <= hit_way;
            bus.rsp_halt_mask <= halt_mask;
         end
         if (acc_fill) begin
            bus.fill_way  <= fill_sel;
            bus.evict_tag <= tags[bus.fill_index][fill_sel];
            vld[bus.fill_index][fill_sel] <= 1'b1;
         end
         if (acc_inv) vld[bus.inv_index][bus.inv_way] <= 1'b0;
         if (upd_en) age[upd_idx] <= lru_nxt;
         if (fl_clr) begin
            vld[fl_cnt] <= '0;
            for (int w = 0; w < WAYS; w++) age[fl_cnt][w] <= WAY_W'(w);
         end
      end
   end
endmodule

// File: tb/tb_cache_tag_store.sv
// tb_cache_tag_store: directed and random stimulus against a
// recency-list reference model, checked through a scoreboard.
module tb_cache_tag_store;
   import cache_tag_pkg::*;

   localparam int TAG_W  = 20;
   localparam int HALT_W = 4;
   localparam int SETS   = 16;
   localparam int WAYS   = 4;
   localparam int IDX_W  = 4;
   localparam int WAY_W  = 2;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   cache_tag_store_if #(
      .TAG_W(TAG_W), .IDX_W(IDX_W), .WAY_W(WAY_W), .WAYS(WAYS)
   ) bus ();

   cache_tag_store #(
      .TAG_W(TAG_W), .HALT_W(HALT_W), .SETS(SETS), .WAYS(WAYS)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit hit; int way; int mask; int due;
   } rsp_e;
   typedef struct {
      int way; bit ev; int et; int due;
   } fill_e;

   tag_entry_t ent [SETS][WAYS];
   int   ord [SETS][WAYS];   // recency list, index 0 = most recent
   int   busy;
   bit   mdone;
   rsp_e  rq [$];
   fill_e fq [$];
   int   cyc_n = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(string n, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
      end
   endtask

   function automatic void touch(int s, int t);
      int p = 0;
      for (int i = 0; i < WAYS; i++) if (ord[s][i] == t) p = i;
      for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
      ord[s][0] = t;
   endfunction

   function automatic void clr_set(int s);
      for (int w = 0; w < WAYS; w++) begin
         ent[s][w].valid = 1'b0;
         ord[s][w] = w;
      end
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         clr_set(s);
         for (int w = 0; w < WAYS; w++) ent[s][w].tag = '0;
      end
      busy = 0;
      mdone = 1'b0;
      rq.delete();
      fq.delete();
   endfunction

   function automatic bit present(int s, int t);
      bit p = 1'b0;
      for (int w = 0; w < WAYS; w++)
         if (ent[s][w].valid && ent[s][w].tag == TAG_W'(t)) p = 1'b1;
      return p;
   endfunction

   task automatic cyc(bit lv, int li, int lt, bit fv, int fi, int ft,
                      bit iv, int ii, int iw, bit fr);
      bit rdy, nd;
      rsp_e r;
      fill_e f;
      logic [31:0] ltv;
      bus.lkp_valid  = lv;
      bus.lkp_index  = IDX_W'(li);
      bus.lkp_tag    = TAG_W'(lt);
      bus.fill_valid = fv;
      bus.fill_index = IDX_W'(fi);
      bus.fill_tag   = TAG_W'(ft);
      bus.inv_valid  = iv;
      bus.inv_index  = IDX_W'(ii);
      bus.inv_way    = WAY_W'(iw);
      bus.flush_req  = fr;
      #1;
      rdy = (busy == 0);
      chk("ready", 32'(bus.ready), 32'(rdy));
      chk("inv_ready", 32'(bus.inv_ready), 32'(rdy & ~fv));
      chk("flush_done", 32'(bus.flush_done), 32'(mdone));
      ltv = lt;
      if (rdy && lv) begin
         r.hit = 1'b0; r.way = 0; r.mask = 0; r.due = cyc_n + 1;
         for (int w = WAYS-1; w >= 0; w--) begin
            if (ent[li][w].valid && ent[li][w].tag[3:0] == ltv[3:0])
               r.mask |= (1 << w);
            if (ent[li][w].valid && ent[li][w].tag == ltv[19:0]) begin
               r.hit = 1'b1; r.way = w;
            end
         end
         rq.push_back(r);
         if (r.hit && !(fv && fi == li)) touch(li, r.way);
      end
      if (rdy && fv) begin
         f.way = ord[fi][WAYS-1];
         for (int w = WAYS-1; w >= 0; w--) if (!ent[fi][w].valid) f.way = w;
         f.ev = ent[fi][f.way].valid;
         f.et = int'(ent[fi][f.way].tag);
         f.due = cyc_n + 1;
         fq.push_back(f);
         ent[fi][f.way].valid = 1'b1;
         ent[fi][f.way].tag = TAG_W'(ft);
         touch(fi, f.way);
      end
      if (rdy && iv && !fv) ent[ii][iw].valid = 1'b0;
      nd = 1'b0;
      if (busy > 0) begin
         clr_set(SETS - busy);
         nd = (busy == 1);
         busy--;
      end else if (fr) begin
         busy = SETS;
      end
      mdone = nd;
      @(posedge clk); #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      bus.lkp_valid = 0; bus.fill_valid = 0; bus.inv_valid = 0;
      bus.flush_req = 0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
      chk("rst_ready", 32'(bus.ready), 1);
      chk("rst_inv_ready", 32'(bus.inv_ready), 1);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      chk("rst_rsp_hit", 32'(bus.rsp_hit), 0);
      chk("rst_rsp_mask", 32'(bus.rsp_halt_mask), 0);
      chk("rst_fill_done", 32'(bus.fill_done), 0);
      chk("rst_evict_valid", 32'(bus.evict_valid), 0);
      chk("rst_evict_tag", 32'(bus.evict_tag), 0);
      chk("rst_flush_done", 32'(bus.flush_done), 0);
   endtask

   always @(negedge clk) begin
      bit er, ef;
      if (!reset) begin
         er = (rq.size() > 0) && (rq[0].due == cyc_n);
         if (er || bus.rsp_valid === 1'b1) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(er));
            if (er) begin
               if (bus.rsp_valid === 1'b1) begin
                  chk("rsp_hit", 32'(bus.rsp_hit), 32'(rq[0].hit));
                  chk("rsp_way", 32'(bus.rsp_way), rq[0].way);
                  chk("rsp_halt_mask", 32'(bus.rsp_halt_mask), rq[0].mask);
               end
               void'(rq.pop_front());
            end
         end
         ef = (fq.size() > 0) && (fq[0].due == cyc_n);
         if (ef || bus.fill_done === 1'b1) begin
            chk("fill_done", 32'(bus.fill_done), 32'(ef));
            if (ef) begin
               if (bus.fill_done === 1'b1) begin
                  chk("fill_way", 32'(bus.fill_way), fq[0].way);
                  chk("evict_valid", 32'(bus.evict_valid), 32'(fq[0].ev));
                  if (fq[0].ev) chk("evict_tag", 32'(bus.evict_tag), fq[0].et);
               end
               void'(fq.pop_front());
            end
         end
      end
   end

   function automatic int rtag();
      return int'(($urandom_range(0, 3) << 16) | $urandom_range(0, 3));
   endfunction

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      bit lv, fv, iv, fr;
      int li, fi;
      do_reset();

      cyc(1, 3, 'h12345, 0, 0, 0, 0, 0, 0, 0);
      chk("tp1_valid", 32'(bus.rsp_valid), 1);
      chk("tp1_hit", 32'(bus.rsp_hit), 0);
      chk("tp1_mask", 32'(bus.rsp_halt_mask), 0);

      cyc(0, 0, 0, 1, 3, 'hA0001, 0, 0, 0, 0);
      chk("tp2_way0", 32'(bus.fill_way), 0);
      cyc(0, 0, 0, 1, 3, 'hB0002, 0, 0, 0, 0);
      chk("tp2_way1", 32'(bus.fill_way), 1);
      cyc(0, 0, 0, 1, 3, 'hC0003, 0, 0, 0, 0);
      chk("tp2_way2", 32'(bus.fill_way), 2);
      cyc(0, 0, 0, 1, 3, 'hD0004, 0, 0, 0, 0);
      chk("tp2_way3", 32'(bus.fill_way), 3);
      chk("tp2_noevict", 32'(bus.evict_valid), 0);
      cyc(1, 3, 'hC0003, 0, 0, 0, 0, 0, 0, 0);
      chk("tp2_hit", 32'(bus.rsp_hit), 1);
      chk("tp2_hitway", 32'(bus.rsp_way), 2);
      cyc(1, 3, 'hE0003, 0, 0, 0, 0, 0, 0, 0);
      chk("tp2_miss", 32'(bus.rsp_hit), 0);
      chk("tp2_mask", 32'(bus.rsp_halt_mask), 'b0100);

      cyc(1, 3, 'hA0001, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 3, 'hF0005, 0, 0, 0, 0);
      chk("tp3_way", 32'(bus.fill_way), 1);
      chk("tp3_evict", 32'(bus.evict_valid), 1);
      chk("tp3_etag", 32'(bus.evict_tag), 'hB0002);

      cyc(0, 0, 0, 1, 5, 'h55555, 1, 3, 2, 0);
      chk("tp4_fill_done", 32'(bus.fill_done), 1);
      cyc(0, 0, 0, 0, 0, 0, 1, 3, 2, 0);
      cyc(1, 3, 'hC0003, 0, 0, 0, 0, 0, 0, 0);
      chk("tp4_miss", 32'(bus.rsp_hit), 0);

      cyc(0, 0, 0, 1, 0, 'h11110, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 7, 'h11117, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 15, 'h1111F, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < SETS; i++)
         cyc(1, i, 'h11117, 1, i, rtag(), 1, i, 0, 0);
      chk("tp5_done", 32'(bus.flush_done), 1);
      chk("tp5_ready", 32'(bus.ready), 1);
      for (int s = 0; s < SETS; s++)
         cyc(1, s, 'h11110 + s, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 9, 'h22229, 0, 0, 0, 0);
      chk("tp5_way0", 32'(bus.fill_way), 0);

      cyc(0, 0, 0, 1, 2, 'h33332, 0, 0, 0, 0);
      cyc(0, 0, 0, 1, 12, 'h3333C, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(7);
      do_reset();
      for (int s = 0; s < SETS; s++)
         cyc(1, s, 'h33330 + s, 0, 0, 0, 0, 0, 0, 0);
      idle(4);

      for (int n = 0; n < 4000; n++) begin
         lv = ($urandom_range(0, 1) == 1);
         li = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SETS-1))
                                          : int'($urandom_range(0, 3));
         fv = ($urandom_range(0, 3) == 0);
         fi = lv ? li : int'($urandom_range(0, 3));
         iv = ($urandom_range(0, 5) == 0);
         fr = ($urandom_range(0, 299) == 0);
         begin
            int lt, ft;
            lt = rtag();
            ft = rtag();
            if (present(fi, ft)) fv = 1'b0;
            cyc(lv, li, lt, fv, fi, ft, iv, int'($urandom_range(0, 3)),
                int'($urandom_range(0, WAYS-1)), fr);
         end
      end
      idle(SETS + 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cache_tag_store.md
Name: cache_tag_store

Overview:
Parametrised set-associative tag store with way-halting, the successor to the fixed-width main/halt tag flip-flop arrays. It holds a valid bit, a full tag and true-LRU age per way per set. It performs a one-cycle registered lookup with halt-tag pre-filtering, LRU-victim fill with eviction report, single-way invalidate, and a whole-array flush sequencer. It sits between the cache controller (address split into index/tag) and the data array, which consumes hit_way/fill_way.

Parameters:
TAG_W, 20, full tag width in bits.
HALT_W, 4, halt tag width; the halt tag is tag[HALT_W-1:0]; must satisfy 1 <= HALT_W <= TAG_W.
SETS, 16, number of sets; power of two, >= 2.
WAYS, 4, associativity; power of two, 2..8.
Derived: IDX_W = clog2(SETS), WAY_W = clog2(WAYS).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
ready  out  1  high when idle (not flushing)
lkp_valid  in  1  lookup request
lkp_index  in  IDX_W  lookup set
lkp_tag  in  TAG_W  lookup tag
rsp_valid  out  1  lookup result valid (one cycle after request)
rsp_hit  out  1  hit
rsp_way  out  WAY_W  hitting way (0 on miss)
rsp_halt_mask  out  WAYS  ways that are valid with a matching halt tag
fill_valid  in  1  fill request
fill_index  in  IDX_W  fill set
fill_tag  in  TAG_W  tag to install
fill_done  out  1  fill completed (one cycle after request)
fill_way  out  WAY_W  way written
evict_valid  out  1  a valid line was replaced
evict_tag  out  TAG_W  tag of the replaced line
inv_valid  in  1  invalidate request
inv_index  in  IDX_W  invalidate set
inv_way  in  WAY_W  invalidate way
inv_ready  out  1  invalidate accepted this cycle
flush_req  in  1  start flush (sampled only when ready=1)
flush_done  out  1  one-cycle pulse at the end of a flush

Behaviour:
- Reset: all valid bits cleared; the age of way w = w in every set. Outputs: ready=1; inv_ready=1; all other outputs 0. Reset mid-flush aborts the flush and produces no flush_done.
- Requests are accepted only while ready=1; while ready=0, lkp_valid, fill_valid and inv_valid are ignored.
- Lookup: the array state is sampled in the request cycle, and the response is registered 1 cycle later.
  - halt_mask[w] = valid[w] & (tag[w][HALT_W-1:0] == lkp_tag[HALT_W-1:0]).
  - A full compare is done only on halt_mask ways.
  - At most one way hits; uniqueness is guaranteed by the controller, and the lowest index wins if it is violated.
  - On a hit, LRU is updated.
  - rsp_* hold their value until the next lookup; rsp_valid is a 1-cycle pulse.
- Fill victim selection: the lowest-index invalid way; otherwise the way with age == WAYS-1.
  - The tag is written with valid=1 and LRU is updated.
  - fill_done, fill_way, evict_valid and evict_tag are registered 1 cycle later.
  - evict_valid=1 only if the victim was valid.
  - A fill of a tag that is already present is a controller error and is not checked.
- LRU update (touch way t, old age a): age[t]=0; every way with age < a is incremented; all others are unchanged. Ages stay a permutation of 0..WAYS-1.
- Invalidate: clears valid[inv_way]; the age is unchanged. inv_ready = ready & ~fill_valid.
  - When fill and invalidate are presented together, the fill wins and the invalidate must be held.
- Simultaneous lookup and fill/invalidate:
  - The lookup sees the pre-write state (read-before-write).
  - If the lookup hits and the fill is to the same index, only the fill's LRU update is applied. Victim selection uses the pre-update state.
- Flush, on flush_req while ready=1:
  - ready drops the next cycle.
  - Set s is cleared (valid=0, ages reset to way index) on flush cycle s, for s = 0..SETS-1, taking SETS cycles.
  - flush_done pulses in the cycle after the last set is cleared, and ready returns to 1 in that same cycle.
  - Requests presented in the flush_req cycle itself are processed normally.
- Index 0 and index SETS-1 wrap nothing; there is no address arithmetic beyond the set decode.

Decomposition:
- Package cache_tag_pkg holds:
  - the clog2 helper;
  - the default width constants;
  - a tag_entry struct {valid, tag[TAG_W-1:0]};
  - the flush FSM state enum {FL_IDLE, FL_RUN, FL_DONE}.
- One sub-module, cache_tag_lru: per-set age vector in; touch way in; next-age vector and victim-way out. It is purely combinational and instantiated once, shared between the lookup and fill update paths through a select.

Test Plan (TAG_W=20, HALT_W=4, SETS=16, WAYS=4):
1. Reset, then lookup index 3, tag 0x12345 -> next cycle rsp_valid=1, rsp_hit=0, rsp_halt_mask=0000.
2. Fill index 3 with tags 0xA0001, 0xB0002, 0xC0003, 0xD0004 -> fill_way = 0,1,2,3 and evict_valid=0 throughout. Then lookup 0xC0003 -> hit, way 2. Then lookup 0xE0003 -> miss with rsp_halt_mask=0100.
3. After scenario 2, look up 0xA0001, then fill 0xF0005 to index 3 -> victim way 1, evict_valid=1, evict_tag=0xB0002.
4. Invalidate index 3 way 2 together with a fill to index 5 -> fill_done next cycle, inv_ready=0. Hold the invalidate one more cycle -> accepted. Then lookup 0xC0003 -> miss.
5. Fill several sets, then pulse flush_req -> ready=0 for 16 cycles, then flush_done pulses with ready=1. Every lookup after that misses, and the next fill to any set uses way 0.
6. Assert reset at flush cycle 7 -> no flush_done, ready=1 the cycle after reset, all sets invalid.
